// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - scratchpad-to-systolic-array matmul sequencer
// Loads weights and inputs, feeds a skewed input wavefront, collects result rows and writes them back.
module matmul_sequencer #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_matmul,
  input  logic [31:0]            input_addr,
  input  logic [31:0]            weight_addr,
  input  logic [31:0]            output_addr,
  output logic                   matmul_finished,
  output logic                   busy,
  output logic                   sp_read_en,
  output logic                   sp_write_en,
  output logic [31:0]            sp_addr,
  output logic [DW-1:0]          sp_wdata,
  input  logic [DW-1:0]          sp_rdata,
  input  logic                   sp_ready,
  output logic                   sa_w_load,
  output logic [$clog2(N)-1:0]   sa_w_row,
  output logic [N*DW-1:0]        sa_w_data,
  output logic                   sa_in_valid,
  output logic [N*DW-1:0]        sa_in_data,
  input  logic                   sa_out_valid,
  input  logic [N*DW-1:0]        sa_out_data
);

  localparam int RW = $clog2(N);
  localparam int TW = $clog2(2 * N);
  localparam int CW = $clog2(N + 1);
  localparam int NW = N * DW;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_I, FEED, DRAIN, WRITE, DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]         in_base, w_base, out_base;
  logic [RW-1:0]       row, col;
  logic [TW-1:0]       tcnt;
  logic [CW-1:0]       rcnt;
  logic [N*N*DW-1:0]   x_buf;
  logic [N*N*DW-1:0]   res_buf;
  logic [31:0]         elem_idx;
  logic [31:0]         elem_off;
  logic                last_elem;
  logic                rows_done;
  logic                capture;

  // Matrices are stored flat, row-major, element (r,c) at bit offset (r*N+c)*DW.
  assign elem_idx  = 32'(row) * 32'(N) + 32'(col);
  assign elem_off  = elem_idx << 2;
  assign last_elem = (row == RW'(N - 1)) && (col == RW'(N - 1));
  assign capture   = (state == FEED || state == DRAIN) && sa_out_valid && (rcnt < CW'(N));
  // A row arriving this cycle counts, so a final row landing in the last FEED cycle skips DRAIN.
  assign rows_done = (rcnt == CW'(N)) || ((rcnt == CW'(N - 1)) && sa_out_valid);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    busy            = (state != IDLE);
    matmul_finished = 1'b0;
    sp_read_en      = 1'b0;
    sp_write_en     = 1'b0;
    sp_addr         = '0;
    sp_wdata        = '0;
    case (state)
      IDLE: begin
        if (start_matmul) state_next = LOAD_W;
      end
      LOAD_W: begin
        sp_read_en = 1'b1;
        sp_addr    = w_base + elem_off;
        if (sp_ready && last_elem) state_next = LOAD_I;
      end
      LOAD_I: begin
        sp_read_en = 1'b1;
        sp_addr    = in_base + elem_off;
        if (sp_ready && last_elem) state_next = FEED;
      end
      FEED: begin
        if (tcnt == TW'(2 * N - 2)) state_next = rows_done ? WRITE : DRAIN;
      end
      DRAIN: begin
        if (rows_done) state_next = WRITE;
      end
      WRITE: begin
        sp_write_en = 1'b1;
        sp_addr     = out_base + elem_off;
        sp_wdata    = res_buf[elem_idx * DW +: DW];
        if (sp_ready && last_elem) state_next = DONE;
      end
      DONE: begin
        matmul_finished = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane k at feed step t carries X[t-k][k]; outside the diagonal band it is zero.
  always_comb begin
    int tr;
    tr          = 0;
    sa_in_valid = (state == FEED);
    sa_in_data  = '0;
    if (state == FEED) begin
      for (int k = 0; k < N; k++) begin
        tr = int'(tcnt) - k;
        if (tr >= 0 && tr < N)
          sa_in_data[k * DW +: DW] = x_buf[(tr * N + k) * DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_base   <= '0;
      w_base    <= '0;
      out_base  <= '0;
      row       <= '0;
      col       <= '0;
      tcnt      <= '0;
      rcnt      <= '0;
      x_buf     <= '0;
      res_buf   <= '0;
      sa_w_load <= 1'b0;
      sa_w_row  <= '0;
      sa_w_data <= '0;
    end else begin
      sa_w_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start_matmul) begin
            in_base  <= input_addr;
            w_base   <= weight_addr;
            out_base <= output_addr;
            row      <= '0;
            col      <= '0;
            tcnt     <= '0;
            rcnt     <= '0;
          end
        end
        LOAD_W, LOAD_I, WRITE: begin
          if (sp_ready) begin
            if (state == LOAD_W) begin
              sa_w_data[32'(col) * DW +: DW] <= sp_rdata;
              if (col == RW'(N - 1)) begin
                sa_w_load <= 1'b1;
                sa_w_row  <= row;
              end
            end
            if (state == LOAD_I) x_buf[elem_idx * DW +: DW] <= sp_rdata;
            if (col == RW'(N - 1)) begin
              col <= '0;
              row <= (row == RW'(N - 1)) ? '0 : row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end
        end
        FEED: tcnt <= tcnt + TW'(1);
        default: ;
      endcase
      if (capture) begin
        res_buf[32'(rcnt) * 32'(NW) +: NW] <= sa_out_data;
        rcnt <= rcnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - scoreboard bench for matmul_sequencer
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_matmul_sequencer;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NW = N * DW;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            start_matmul = 1'b0;
  logic [31:0]     input_addr = '0, weight_addr = '0, output_addr = '0;
  logic            matmul_finished, busy, sp_read_en, sp_write_en;
  logic [31:0]     sp_addr;
  logic [DW-1:0]   sp_wdata;
  logic [DW-1:0]   sp_rdata = '0;
  logic            sp_ready = 1'b0;
  logic            sa_w_load;
  logic [1:0]      sa_w_row;
  logic [NW-1:0]   sa_w_data;
  logic            sa_in_valid;
  logic [NW-1:0]   sa_in_data;
  logic            sa_out_valid = 1'b0;
  logic [NW-1:0]   sa_out_data = '0;

  matmul_sequencer #(.N(N), .DW(DW)) dut (
    .clk(clk), .n_rst(n_rst), .start_matmul(start_matmul),
    .input_addr(input_addr), .weight_addr(weight_addr), .output_addr(output_addr),
    .matmul_finished(matmul_finished), .busy(busy),
    .sp_read_en(sp_read_en), .sp_write_en(sp_write_en), .sp_addr(sp_addr),
    .sp_wdata(sp_wdata), .sp_rdata(sp_rdata), .sp_ready(sp_ready),
    .sa_w_load(sa_w_load), .sa_w_row(sa_w_row), .sa_w_data(sa_w_data),
    .sa_in_valid(sa_in_valid), .sa_in_data(sa_in_data),
    .sa_out_valid(sa_out_valid), .sa_out_data(sa_out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int ntests = 0, nfail = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0;
  bit stall_mode = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rd [$];
  logic [NW-1:0] exp_feed [$];
  wr_t exp_wr [$];
  int exp_lat [$];

  // X = 1..16 row-major; lanes listed lane0..lane3 per feed step.
  int feed_tbl [7][4] = '{'{1, 0, 0, 0}, '{5, 2, 0, 0}, '{9, 6, 3, 0}, '{13, 10, 7, 4},
                          '{0, 14, 11, 8}, '{0, 0, 15, 12}, '{0, 0, 0, 16}};

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Systolic array model: rebuilds X from the skewed stream, returns X-row * W one cycle after completion.
  logic [NW-1:0] wm [N];
  logic [DW-1:0] xm [N][N];
  int ft = 0;
  logic pend_v = 1'b0;
  logic [NW-1:0] pend_d = '0;

  always @(negedge clk) begin
    if (!n_rst) begin
      ft = 0;
      pend_v = 1'b0;
    end else begin
      if (sa_w_load) wm[sa_w_row] = sa_w_data;
      pend_v = 1'b0;
      if (sa_in_valid) begin
        for (int k = 0; k < N; k++)
          if (ft - k >= 0 && ft - k < N) xm[ft - k][k] = sa_in_data[k * DW +: DW];
        if (ft >= N - 1 && ft - (N - 1) < N) begin
          pend_v = 1'b1;
          for (int c = 0; c < N; c++) begin
            logic [DW-1:0] acc;
            acc = '0;
            for (int k = 0; k < N; k++) acc += xm[ft - (N - 1)][k] * wm[k][c * DW +: DW];
            pend_d[c * DW +: DW] = acc;
          end
        end
        ft++;
      end else begin
        ft = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    sp_ready     = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    sp_rdata     = mem.exists(sp_addr) ? mem[sp_addr] : '0;
    sa_out_valid = pend_v;
    sa_out_data  = pend_d;
  end

  logic          prev_pend = 1'b0;
  logic [NW-1:0] prev_sig = '0;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_pend = 1'b0;
    end else begin
      if (sp_read_en || sp_write_en) chk("rw_exclusive", NW'(sp_read_en & sp_write_en), '0);
      if (prev_pend) chk("stall_hold", NW'({sp_read_en, sp_write_en, sp_addr, sp_wdata}), prev_sig);
      prev_pend = (sp_read_en || sp_write_en) && !sp_ready;
      prev_sig  = NW'({sp_read_en, sp_write_en, sp_addr, sp_wdata});
      if (sp_read_en && sp_ready) begin
        if (exp_rd.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL rd_addr: got unexpected read at %h required none", sp_addr);
        end else chk("rd_addr", NW'(sp_addr), NW'(exp_rd.pop_front()));
      end
      if (sp_write_en && sp_ready) begin
        if (exp_wr.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL wr: got unexpected write %h@%h required none", sp_wdata, sp_addr);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr_data", NW'({sp_addr, sp_wdata}), NW'({w.a, w.d}));
        end
      end
      if (sa_in_valid) begin
        if (exp_feed.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL feed: got unexpected vector %h required none", sa_in_data);
        end else chk("feed_skew", sa_in_data, exp_feed.pop_front());
      end
      if (matmul_finished) begin
        done_cnt++;
        chk("busy_in_done", NW'(busy), NW'(1));
        if (exp_lat.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL finished: got unexpected pulse required none");
        end else begin
          int lat;
          lat = exp_lat.pop_front();
          if (lat >= 0) chk("latency", NW'(cyc - start_cyc + 1), NW'(lat));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, NW'({matmul_finished, busy, sp_read_en, sp_write_en, sp_addr,
                             sp_wdata, sa_w_load, sa_w_row, sa_in_valid}), '0);
    chk({tag, "_wdata"}, sa_w_data, '0);
    chk({tag, "_indata"}, sa_in_data, '0);
  endtask

  task automatic prep(input logic [31:0] wa, input logic [31:0] ia, input logic [31:0] oa, input int lat);
    logic [NW-1:0] v;
    for (int i = 0; i < N * N; i++) begin
      mem[wa + 32'(4 * i)] = (i % (N + 1) == 0) ? 32'd1 : 32'd0;
      mem[ia + 32'(4 * i)] = 32'(i + 1);
      exp_rd.push_back(wa + 32'(4 * i));
    end
    for (int i = 0; i < N * N; i++) exp_rd.push_back(ia + 32'(4 * i));
    for (int t = 0; t < 2 * N - 1; t++) begin
      for (int k = 0; k < N; k++) v[k * DW +: DW] = 32'(feed_tbl[t][k]);
      exp_feed.push_back(v);
    end
    for (int i = 0; i < N * N; i++) exp_wr.push_back('{oa + 32'(4 * i), 32'(i + 1)});
    exp_lat.push_back(lat);
  endtask

  task automatic run_op(input string tag, input logic [31:0] wa, input logic [31:0] ia,
                        input logic [31:0] oa, input bit stall, input bit hold, input int lat);
    int d0;
    bit seen;
    seen = 1'b0;
    stall_mode = stall;
    prep(wa, ia, oa, lat);
    @(negedge clk);
    weight_addr = wa; input_addr = ia; output_addr = oa;
    start_matmul = 1'b1;
    start_cyc = cyc;
    d0 = done_cnt;
    if (!hold) begin
      @(negedge clk);
      start_matmul = 1'b0;
    end
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (matmul_finished) seen = 1'b1;
    end
    start_matmul = 1'b0;
    if (!seen) begin
      ntests++; nfail++;
      $display("FAIL %s_timeout: got no finished pulse required one within 3000 cycles", tag);
    end
    repeat (8) @(negedge clk);
    chk({tag, "_idle_busy"}, NW'(busy), '0);
    chk({tag, "_pulse_count"}, NW'(done_cnt - d0), NW'(1));
    chk({tag, "_rd_left"}, NW'(exp_rd.size()), '0);
    chk({tag, "_feed_left"}, NW'(exp_feed.size()), '0);
    chk({tag, "_wr_left"}, NW'(exp_wr.size()), '0);
  endtask

  initial begin
    bit hit;
    hit = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Abort mid-LOAD_I with an asynchronous reset.
    stall_mode = 1'b0;
    prep(32'h100, 32'h200, 32'h300, -1);
    weight_addr = 32'h100; input_addr = 32'h200; output_addr = 32'h300;
    start_matmul = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_matmul = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (sp_read_en && sp_addr == 32'h208) hit = 1'b1;
    end
    chk("reached_load_i", NW'(hit), NW'(1));
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("abort");
    exp_rd.delete(); exp_feed.delete(); exp_wr.delete(); exp_lat.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_restart", NW'(busy), '0);

    run_op("basic", 32'h100, 32'h200, 32'h300, 1'b0, 1'b0, 3 * N * N + 2 * N - 1 + 1 + 2);
    run_op("stall", 32'h100, 32'h200, 32'h300, 1'b1, 1'b0, -1);
    run_op("hold", 32'h100, 32'h200, 32'h300, 1'b0, 1'b1, 58);
    run_op("wrap", 32'hFFFF_FFF8, 32'h200, 32'h300, 1'b0, 1'b0, 58);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
